// File: rtl/rsf_pkg.sv
// rsf_pkg: shared defaults, index-width helper and stack-operation encoding
package rsf_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int NREGS_DEF       = 16;
    localparam int STACK_DEPTH_DEF = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // bit 0 = push request, bit 1 = pop request
    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        SWAP = 2'd3
    } stack_op_e;

endpackage

// File: rtl/lifo_stack.sv
// lifo_stack: LIFO storage with occupancy pointer, full/empty decode and sticky error flags
module lifo_stack
    import rsf_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    localparam int AW         = idx_w(STACK_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_en,
    input  logic              pop_en,
    input  logic [DATA_W-1:0] push_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] pop_data,
    output logic [AW:0]       sp,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem [STACK_DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     tptr;
    stack_op_e         op;

    assign op    = stack_op_e'({pop_en, push_en});
    assign full  = sp == (AW + 1)'(STACK_DEPTH);
    assign empty = sp == '0;
    assign wptr  = sp[AW-1:0];
    // when full, the low bits wrap to 0 so minus one still lands on the top slot
    assign tptr  = wptr - 1'b1;

    // stack update; a same-cycle error overrides err_clr because it is assigned later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
            pop_data  <= '0;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            case (op)
                PUSH: begin
                    if (full) overflow <= 1'b1;
                    else begin
                        mem[wptr] <= push_data;
                        sp        <= sp + 1'b1;
                    end
                end
                POP: begin
                    if (empty) underflow <= 1'b1;
                    else begin
                        pop_data <= mem[tptr];
                        sp       <= sp - 1'b1;
                    end
                end
                SWAP: begin
                    if (empty) pop_data <= push_data;
                    else begin
                        pop_data  <= mem[tptr];
                        mem[tptr] <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/reg_stack_file.sv
// reg_stack_file: register file with zero register plus independent LIFO; REG_STACK_BYPASS_EN enables write-to-read forwarding
module reg_stack_file
    import rsf_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NREGS       = NREGS_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    localparam int IW         = idx_w(NREGS),
    localparam int AW         = idx_w(STACK_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_id,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IW-1:0]     rd_id_a,
    input  logic [IW-1:0]     rd_id_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              push_en,
    input  logic              pop_en,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_data,
    output logic [AW:0]       sp,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rd_val_a;
    logic [DATA_W-1:0] rd_val_b;

    // read selection; register 0 is hardwired to zero
    always_comb begin
`ifdef REG_STACK_BYPASS_EN
        rd_val_a = (rd_id_a == '0) ? '0 : (wr_en && wr_id == rd_id_a) ? wr_data : regs[rd_id_a];
        rd_val_b = (rd_id_b == '0) ? '0 : (wr_en && wr_id == rd_id_b) ? wr_data : regs[rd_id_b];
`else
        rd_val_a = (rd_id_a == '0) ? '0 : regs[rd_id_a];
        rd_val_b = (rd_id_b == '0) ? '0 : regs[rd_id_b];
`endif
    end

    // register writes and registered read ports
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            if (wr_en && wr_id != '0) regs[wr_id] <= wr_data;
            if (rd_en) begin
                rd_data_a <= rd_val_a;
                rd_data_b <= rd_val_b;
            end
        end
    end

    lifo_stack #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk       (clk),
        .reset     (reset),
        .push_en   (push_en),
        .pop_en    (pop_en),
        .push_data (push_data),
        .err_clr   (err_clr),
        .pop_data  (pop_data),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

endmodule

// File: tb/tb_reg_stack_file.sv
// tb_reg_stack_file: directed self-checking bench for reg_stack_file
module tb_reg_stack_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_id;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_id_a;
    logic [3:0]  rd_id_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        push_en;
    logic        pop_en;
    logic [15:0] push_data;
    logic [15:0] pop_data;
    logic [3:0]  sp;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underflow;
    logic        err_clr;

    int n_cmp = 0;
    int n_bad = 0;

    reg_stack_file dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_id     (wr_id),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_id_a   (rd_id_a),
        .rd_id_b   (rd_id_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .push_en   (push_en),
        .pop_en    (pop_en),
        .push_data (push_data),
        .pop_data  (pop_data),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; push_en = 0; pop_en = 0; err_clr = 0;
    endtask

    initial begin
        reset = 0; idle();
        wr_id = 0; wr_data = 0; rd_id_a = 0; rd_id_b = 0; push_data = 0;
        tick(); tick();
        check("rst_sp", sp, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_rda", rd_data_a, 0);
        check("rst_pop", pop_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);
        reset = 1;

        // write r2 then read r2 / r0
        wr_en = 1; wr_id = 2; wr_data = 16'h000F; tick();
        idle(); rd_en = 1; rd_id_a = 2; rd_id_b = 0; tick();
        check("rd_r2", rd_data_a, 16'h000F);
        check("rd_r0", rd_data_b, 0);

        // write to r0 is discarded
        idle(); wr_en = 1; wr_id = 0; wr_data = 16'h1234; tick();
        idle(); rd_en = 1; rd_id_a = 0; rd_id_b = 2; tick();
        check("r0_zero", rd_data_a, 0);
        check("rd_b_r2", rd_data_b, 16'h000F);

        // rd_en low holds read data
        idle(); rd_id_a = 2; rd_id_b = 0; tick();
        check("rd_hold_a", rd_data_a, 0);
        check("rd_hold_b", rd_data_b, 16'h000F);

        // fill the stack, then overflow
        idle(); push_en = 1;
        for (int i = 1; i <= 8; i++) begin
            push_data = 16'(i); tick();
        end
        check("fill_sp", sp, 8);
        check("fill_full", full, 1);
        check("fill_ovf", overflow, 0);
        push_data = 16'd9; tick();
        check("ovf_sp", sp, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_full", full, 1);

        // drain in LIFO order
        idle(); pop_en = 1;
        for (int i = 8; i >= 1; i--) begin
            tick();
            check("drain", pop_data, 32'(i));
        end
        check("drain_sp", sp, 0);
        check("drain_empty", empty, 1);
        check("ovf_sticky", overflow, 1);
        idle(); err_clr = 1; tick();
        check("ovf_clr", overflow, 0);

        // underflow
        idle(); pop_en = 1; tick();
        check("udf_flag", underflow, 1);
        check("udf_pop_hold", pop_data, 1);
        check("udf_sp", sp, 0);
        idle(); err_clr = 1; tick();
        check("udf_clr", underflow, 0);

        // new error beats err_clr
        idle(); pop_en = 1; err_clr = 1; tick();
        check("udf_win", underflow, 1);
        idle(); err_clr = 1; tick();
        check("udf_clr2", underflow, 0);

        // swap with sp=3
        idle(); push_en = 1;
        for (int i = 1; i <= 3; i++) begin
            push_data = 16'(i); tick();
        end
        check("sw_pre_sp", sp, 3);
        push_data = 16'hAAAA; pop_en = 1; tick();
        check("sw_pop", pop_data, 3);
        check("sw_sp", sp, 3);
        idle(); pop_en = 1; tick();
        check("sw_top", pop_data, 16'hAAAA);
        check("sw_sp2", sp, 2);
        tick(); tick();
        check("sw_last", pop_data, 1);
        check("sw_empty", empty, 1);

        // swap while empty passes through
        idle(); push_en = 1; pop_en = 1; push_data = 16'h7777; tick();
        check("pass_pop", pop_data, 16'h7777);
        check("pass_sp", sp, 0);
        check("pass_udf", underflow, 0);
        check("pass_ovf", overflow, 0);

        // same-cycle write and read of r5
        idle(); wr_en = 1; wr_id = 5; wr_data = 16'h1111; tick();
        wr_data = 16'h5555; rd_en = 1; rd_id_a = 5; rd_id_b = 2; tick();
`ifdef REG_STACK_BYPASS_EN
        check("byp_a", rd_data_a, 16'h5555);
`else
        check("byp_a", rd_data_a, 16'h1111);
`endif
        idle(); rd_en = 1; tick();
        check("byp_after", rd_data_a, 16'h5555);

        // register and stack activity in the same cycle
        idle(); wr_en = 1; wr_id = 3; wr_data = 16'hBEEF; push_en = 1; push_data = 16'h4242; tick();
        idle(); rd_en = 1; rd_id_a = 3; rd_id_b = 5; pop_en = 1; tick();
        check("par_rda", rd_data_a, 16'hBEEF);
        check("par_rdb", rd_data_b, 16'h5555);
        check("par_pop", pop_data, 16'h4242);
        check("par_sp", sp, 0);

        // reset in the middle of a push burst
        idle(); push_en = 1;
        push_data = 16'h0011; tick();
        push_data = 16'h0022; tick();
        check("pre_rst_sp", sp, 2);
        #2 reset = 0;
        #1;
        check("mid_rst_sp", sp, 0);
        check("mid_rst_pop", pop_data, 0);
        check("mid_rst_rda", rd_data_a, 0);
        tick();
        push_data = 16'h0099; reset = 1; tick();
        check("post_rst_sp", sp, 1);
        idle(); pop_en = 1; rd_en = 1; rd_id_a = 3; tick();
        check("post_rst_pop", pop_data, 16'h0099);
        check("post_rst_reg", rd_data_a, 0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
